// File: rtl/sevenseg_decode_pkg.sv
// Shared definitions for the seven-segment frame decoder: glyph table,
// dwell FSM state encoding and digit-select helpers.
package sevenseg_decode_pkg;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } dwell_state_e;

  // Active-low patterns, bit6=g ... bit0=a; entry k is the glyph for nibble k.
  localparam logic [6:0] GLYPH_TABLE [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [6:0] BLANK_SEG = 7'h7F;

  function automatic logic is_onehot(input logic [3:0] dig);
    return (dig != 4'd0) && ((dig & (dig - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] dig_index(input logic [3:0] dig);
    logic [1:0] idx;
    idx = 2'd0;
    case (dig)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sevenseg_decode_glyph_decode.sv
// Combinational segment-pattern to nibble lookup; unknown patterns flag err
// and decode as zero.
import sevenseg_decode_pkg::*;

module sevenseg_glyph_decode (
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       err
);

  // Table lookup against the shared glyph constants
  always_comb begin
    nibble = 4'h0;
    err    = 1'b0;
    case (seg)
      GLYPH_TABLE[0]:  nibble = 4'h0;
      GLYPH_TABLE[1]:  nibble = 4'h1;
      GLYPH_TABLE[2]:  nibble = 4'h2;
      GLYPH_TABLE[3]:  nibble = 4'h3;
      GLYPH_TABLE[4]:  nibble = 4'h4;
      GLYPH_TABLE[5]:  nibble = 4'h5;
      GLYPH_TABLE[6]:  nibble = 4'h6;
      GLYPH_TABLE[7]:  nibble = 4'h7;
      GLYPH_TABLE[8]:  nibble = 4'h8;
      GLYPH_TABLE[9]:  nibble = 4'h9;
      GLYPH_TABLE[10]: nibble = 4'hA;
      GLYPH_TABLE[11]: nibble = 4'hB;
      GLYPH_TABLE[12]: nibble = 4'hC;
      GLYPH_TABLE[13]: nibble = 4'hD;
      GLYPH_TABLE[14]: nibble = 4'hE;
      GLYPH_TABLE[15]: nibble = 4'hF;
      default: begin
        nibble = 4'h0;
        err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sevenseg_decode.sv
// Multiplexed seven-segment display sniffer: debounces each digit over a
// dwell window, assembles four digits into a frame and hands it off.
import sevenseg_decode_pkg::*;

module sevenseg_decode #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  SEG,
  input  logic [3:0]  DIG,
  output logic [15:0] VALUE,
  output logic [3:0]  ERR,
  output logic        VALID,
  input  logic        READY,
  output logic        OVR
);

  localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

  dwell_state_e state_r, state_s;
  logic [7:0]   cnt_r, cnt_s;
  logic [6:0]   prev_seg_r;
  logic [3:0]   prev_dig_r;
  logic [3:0]   cap_r;
  logic [3:0]   slot_nib_r [0:3];
  logic [3:0]   slot_err_r;
  logic         accept_s;
  logic         same_s;
  logic         onehot_s;
  logic         complete_s;
  logic [1:0]   idx_s;
  logic [3:0]   glyph_nib_s;
  logic         glyph_err_s;

  sevenseg_glyph_decode u_glyph (
    .seg    (SEG),
    .nibble (glyph_nib_s),
    .err    (glyph_err_s)
  );

  assign same_s     = (SEG == prev_seg_r) && (DIG == prev_dig_r);
  assign onehot_s   = is_onehot(DIG);
  assign idx_s      = dig_index(DIG);
  assign complete_s = (cap_r == 4'hF);

  // Dwell FSM next-state and counter
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    case (state_r)
      ST_WAIT: begin
        if (onehot_s) begin
          state_s = ST_COUNT;
          cnt_s   = 8'd1;
        end else begin
          cnt_s   = 8'd0;
        end
      end
      ST_COUNT: begin
        if (same_s) begin
          cnt_s = cnt_r + 8'd1;
          if ((cnt_r + 8'd1) == STABLE_LIMIT) begin
            accept_s = 1'b1;
            state_s  = ST_DONE;
          end else begin
            state_s  = ST_COUNT;
          end
        end else if (onehot_s) begin
          cnt_s = 8'd1;
        end else begin
          state_s = ST_WAIT;
          cnt_s   = 8'd0;
        end
      end
      ST_DONE: begin
        // A finished dwell never re-accepts; only a change restarts counting
        if (same_s) begin
          state_s = ST_DONE;
        end else if (onehot_s) begin
          state_s = ST_COUNT;
          cnt_s   = 8'd1;
        end else begin
          state_s = ST_WAIT;
          cnt_s   = 8'd0;
        end
      end
      default: begin
        state_s = ST_WAIT;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // Dwell state, counter and previous-cycle input copies
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_WAIT;
      cnt_r      <= 8'd0;
      prev_seg_r <= BLANK_SEG;
      prev_dig_r <= 4'd0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      prev_seg_r <= SEG;
      prev_dig_r <= DIG;
    end
  end

  // Capture slots; completion clears the mask in the cycle it is seen full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_r      <= 4'd0;
      slot_err_r <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        slot_nib_r[i] <= 4'd0;
      end
    end else begin
      if (accept_s) begin
        cap_r             <= (complete_s ? 4'd0 : cap_r) | (4'd1 << idx_s);
        slot_nib_r[idx_s] <= glyph_nib_s;
        slot_err_r[idx_s] <= glyph_err_s;
      end else if (complete_s) begin
        cap_r <= 4'd0;
      end else begin
        cap_r <= cap_r;
      end
    end
  end

  // Frame handoff to the consumer and sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      VALUE <= 16'h0000;
      ERR   <= 4'h0;
      VALID <= 1'b0;
      OVR   <= 1'b0;
    end else begin
      if (complete_s && (!VALID || READY)) begin
        VALUE <= {slot_nib_r[3], slot_nib_r[2], slot_nib_r[1], slot_nib_r[0]};
        ERR   <= slot_err_r;
        VALID <= 1'b1;
      end else if (complete_s) begin
        OVR   <= 1'b1;
      end else if (VALID && READY) begin
        VALID <= 1'b0;
      end else begin
        VALID <= VALID;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_decode.sv
// Self-checking bench for sevenseg_decode: directed scenarios plus random
// dwell traffic compared cycle by cycle against a run-length reference model.
module tb_sevenseg_decode;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  SEG = 7'h7F;
  logic [3:0]  DIG = 4'd0;
  logic        READY = 1'b0;
  logic [15:0] VALUE;
  logic [3:0]  ERR;
  logic        VALID;
  logic        OVR;

  int tests_run = 0;
  int tests_failed = 0;

  logic [6:0] glyphs [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // reference model state
  logic [6:0]  m_last_seg;
  logic [3:0]  m_last_dig;
  int          m_run;
  bit          m_taken;
  logic [3:0]  m_nib [0:3];
  logic [3:0]  m_e;
  logic [3:0]  m_mask;
  logic [15:0] m_value;
  logic [3:0]  m_err;
  logic        m_valid;
  logic        m_ovr;

  sevenseg_decode #(.STABLE_CYCLES(STABLE)) dut (
    .clk   (clk),
    .rst   (rst),
    .SEG   (SEG),
    .DIG   (DIG),
    .VALUE (VALUE),
    .ERR   (ERR),
    .VALID (VALID),
    .READY (READY),
    .OVR   (OVR)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_glyph(input logic [6:0] s);
    for (int k = 0; k < 16; k++) begin
      if (glyphs[k] == s) return {1'b0, 4'(k)};
    end
    return 5'h10;
  endfunction

  task automatic model_reset();
    m_last_seg = 7'h7F;
    m_last_dig = 4'd0;
    m_run = 0;
    m_taken = 1'b0;
    for (int i = 0; i < 4; i++) m_nib[i] = 4'd0;
    m_e = 4'd0;
    m_mask = 4'd0;
    m_value = 16'h0000;
    m_err = 4'h0;
    m_valid = 1'b0;
    m_ovr = 1'b0;
  endtask

  // One rising edge of the specified behaviour, using inputs held before it.
  task automatic model_step();
    logic [4:0] g;
    int idx;
    if (m_mask == 4'hF) begin
      if (!m_valid || READY) begin
        m_value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
        m_err = m_e;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
      m_mask = 4'd0;
    end else if (m_valid && READY) begin
      m_valid = 1'b0;
    end
    if ($countones(DIG) == 1) begin
      if (SEG == m_last_seg && DIG == m_last_dig) begin
        m_run++;
      end else begin
        m_run = 1;
        m_taken = 1'b0;
      end
      if (m_run >= STABLE && !m_taken) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (DIG[i]) idx = i;
        g = ref_glyph(SEG);
        m_nib[idx] = g[3:0];
        m_e[idx] = g[4];
        m_mask[idx] = 1'b1;
        m_taken = 1'b1;
      end
    end else begin
      m_run = 0;
      m_taken = 1'b0;
    end
    m_last_seg = SEG;
    m_last_dig = DIG;
  endtask

  task automatic cycle(input logic [6:0] s, input logic [3:0] d, input logic r);
    SEG = s;
    DIG = d;
    READY = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic hold(input int i, input logic [6:0] s, input int n, input logic r);
    for (int c = 0; c < n; c++) cycle(s, 4'(1 << i), r);
  endtask

  task automatic send_frame(input logic [15:0] hexval, input logic r);
    for (int i = 0; i < 4; i++) hold(i, glyphs[hexval[4*i +: 4]], STABLE, r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    SEG = 7'h7F;
    DIG = 4'd0;
    READY = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests_run++;
    if (VALUE !== 16'h0000 || ERR !== 4'h0 || VALID !== 1'b0 || OVR !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: VALUE=%h ERR=%b VALID=%b OVR=%b, want 0000 0000 0 0", VALUE, ERR, VALID, OVR);
    end
    do_reset();
    tests_run++;
    if (VALUE !== 16'h0000 || ERR !== 4'h0 || VALID !== 1'b0 || OVR !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: VALUE=%h ERR=%b VALID=%b OVR=%b, want 0000 0000 0 0", VALUE, ERR, VALID, OVR);
    end
  endtask

  task automatic test_basic_frame();
    do_reset();
    hold(0, 7'b1111001, 4, 1'b1);
    hold(1, 7'b0100100, 4, 1'b1);
    hold(2, 7'b0110000, 4, 1'b1);
    hold(3, 7'b0011001, 4, 1'b1);
    cycle(7'h7F, 4'd0, 1'b1);
    tests_run++;
    if (VALID !== 1'b1 || VALUE !== 16'h4321 || ERR !== 4'h0) begin
      tests_failed++;
      $display("FAIL basic_frame: VALID=%b VALUE=%h ERR=%b, want 1 4321 0000", VALID, VALUE, ERR);
    end
    cycle(7'h7F, 4'd0, 1'b1);
    tests_run++;
    if (VALID !== 1'b0 || VALUE !== 16'h4321) begin
      tests_failed++;
      $display("FAIL basic_pulse: VALID=%b VALUE=%h, want 0 4321", VALID, VALUE);
    end
  endtask

  task automatic test_blank_digit();
    do_reset();
    hold(0, 7'b0000000, 4, 1'b1);
    hold(1, 7'b0000000, 4, 1'b1);
    hold(2, 7'b1111111, 4, 1'b1);
    hold(3, 7'b0000000, 4, 1'b1);
    cycle(7'h7F, 4'd0, 1'b1);
    tests_run++;
    if (VALID !== 1'b1 || VALUE !== 16'h8088 || ERR !== 4'b0100) begin
      tests_failed++;
      $display("FAIL blank_digit: VALID=%b VALUE=%h ERR=%b, want 1 8088 0100", VALID, VALUE, ERR);
    end
  endtask

  task automatic test_short_dwell();
    bit seen;
    do_reset();
    hold(0, glyphs[5], 4, 1'b1);
    hold(1, glyphs[6], 3, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cycle(glyphs[6], 4'd0, 1'b1);
      if (VALID) seen = 1'b1;
    end
    hold(2, glyphs[7], 4, 1'b1);
    hold(3, glyphs[8], 4, 1'b1);
    for (int c = 0; c < 3; c++) begin
      cycle(7'h7F, 4'd0, 1'b1);
      if (VALID) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL short_dwell: VALID seen=%b, want 0", seen);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    send_frame(16'h4321, 1'b0);
    cycle(7'h7F, 4'd0, 1'b0);
    tests_run++;
    if (VALID !== 1'b1 || VALUE !== 16'h4321 || OVR !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovr_first: VALID=%b VALUE=%h OVR=%b, want 1 4321 0", VALID, VALUE, OVR);
    end
    send_frame(16'h8765, 1'b0);
    cycle(7'h7F, 4'd0, 1'b0);
    tests_run++;
    if (VALID !== 1'b1 || VALUE !== 16'h4321 || OVR !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovr_set: VALID=%b VALUE=%h OVR=%b, want 1 4321 1", VALID, VALUE, OVR);
    end
    cycle(7'h7F, 4'd0, 1'b1);
    tests_run++;
    if (VALID !== 1'b0 || VALUE !== 16'h4321 || OVR !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovr_drain: VALID=%b VALUE=%h OVR=%b, want 0 4321 1", VALID, VALUE, OVR);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(16'h4321, 1'b0);
    cycle(7'h7F, 4'd0, 1'b0);
    send_frame(16'hBEEF, 1'b0);
    cycle(7'h7F, 4'd0, 1'b1);
    tests_run++;
    if (VALID !== 1'b1 || VALUE !== 16'hBEEF || ERR !== 4'h0 || OVR !== 1'b0) begin
      tests_failed++;
      $display("FAIL back_to_back: VALID=%b VALUE=%h ERR=%b OVR=%b, want 1 beef 0000 0", VALID, VALUE, ERR, OVR);
    end
    cycle(7'h7F, 4'd0, 1'b1);
    tests_run++;
    if (VALID !== 1'b0 || VALUE !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL back_to_back_drain: VALID=%b VALUE=%h, want 0 beef", VALID, VALUE);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit seen;
    do_reset();
    hold(0, glyphs[1], 4, 1'b1);
    hold(1, glyphs[2], 4, 1'b1);
    hold(2, glyphs[3], 4, 1'b1);
    do_reset();
    seen = 1'b0;
    hold(3, glyphs[4], 4, 1'b1);
    for (int c = 0; c < 4; c++) begin
      cycle(7'h7F, 4'd0, 1'b1);
      if (VALID) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0 || VALUE !== 16'h0000 || ERR !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_frame: VALID seen=%b VALUE=%h ERR=%b, want 0 0000 0000", seen, VALUE, ERR);
    end
  endtask

  task automatic test_random();
    logic [6:0] s;
    logic [3:0] d;
    logic r;
    int n;
    int sel;
    int errs;
    do_reset();
    errs = 0;
    for (int it = 0; it < 400; it++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7) s = glyphs[$urandom_range(0, 15)];
      else s = 7'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 8) d = 4'(1 << $urandom_range(0, 3));
      else d = 4'($urandom);
      n = $urandom_range(1, 7);
      for (int c = 0; c < n; c++) begin
        r = ($urandom_range(0, 3) != 0);
        cycle(s, d, r);
        tests_run++;
        if (VALUE !== m_value || ERR !== m_err || VALID !== m_valid || OVR !== m_ovr) begin
          tests_failed++;
          errs++;
          if (errs <= 10)
            $display("FAIL random_cycle it=%0d: VALUE=%h ERR=%b VALID=%b OVR=%b, want %h %b %b %b",
                     it, VALUE, ERR, VALID, OVR, m_value, m_err, m_valid, m_ovr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_blank_digit();
    test_short_dwell();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sevenseg_decode.md
SEVENSEG_DECODE -- requirements
Module: sevenseg_decode

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, consecutive identical cycles required before a digit is accepted; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 SEG  input  7  active-low segment pattern, bit6=g ... bit0=a.
REQ-005 DIG  input  4  active-high digit select, one-hot; DIG[i] marks SEG as belonging to digit i.
REQ-006 VALUE  output  16  decoded frame; VALUE[4i+3:4i] = digit i.
REQ-007 ERR  output  4  per-digit flag; 1 = pattern for that digit was not a legal hex glyph.
REQ-008 VALID  output  1  frame available on VALUE/ERR.
REQ-009 READY  input  1  consumer accepts frame when VALID&&READY at a rising edge.
REQ-010 OVR  output  1  sticky overrun flag.

Function
REQ-011 Glyph table (SEG -> nibble) SHALL be: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0011000->9, 0001000->A, 0000011->B, 1000110->C, 0100001->D, 0000110->E, 0001110->F.
REQ-012 Any other SEG value SHALL decode to nibble 0 with error bit 1.
REQ-013 Dwell FSM states WAIT, COUNT, DONE; registered copies of previous SEG and DIG.
REQ-014 WAIT->COUNT when DIG is one-hot; counter loads 1.
REQ-015 COUNT: if SEG and DIG equal the previous cycle, counter increments; otherwise counter reloads 1, or FSM returns to WAIT if DIG not one-hot.
REQ-016 When counter reaches STABLE_CYCLES, the digit is accepted: nibble and error bit latched into capture slot i, capture bit i set, FSM->DONE.
REQ-017 Accepting a digit whose capture bit is already set SHALL overwrite that slot.
REQ-018 DONE: stays while SEG and DIG unchanged; any change -> COUNT (one-hot DIG, counter=1) or WAIT (otherwise); no second acceptance from one dwell.
REQ-019 Frame completes in the cycle all four capture bits are set; capture bits clear in that same cycle.
REQ-020 On completion with VALID=0, or with VALID&&READY in the same cycle: VALUE/ERR load capture slots, VALID=1 next cycle.
REQ-021 On completion with VALID=1 and READY=0: VALUE/ERR/VALID unchanged, new frame discarded, OVR set.
REQ-022 VALID&&READY without completion: VALID=0 next cycle; VALUE/ERR hold last values.
REQ-023 VALUE/ERR SHALL not change while VALID=1 except per REQ-020.
REQ-024 OVR clears only on rst.
REQ-025 Latency: accepted fourth digit -> VALID high 2 cycles after the acceptance edge at most.

Reset
REQ-026 rst asserted: FSM=WAIT, counter=0, capture bits=0, capture slots=0, VALUE=16'h0000, ERR=4'h0, VALID=0, OVR=0, previous-SEG=7'h7F, previous-DIG=0.
REQ-027 rst mid-dwell or mid-frame SHALL discard all partial state; no frame emitted for pre-reset digits.
REQ-028 First acceptance after rst release SHALL require a full STABLE_CYCLES dwell.

Structure
REQ-029 Shared package holds the 16-entry glyph table, state enum (WAIT/COUNT/DONE) and the blank pattern constant 7'h7F.
REQ-030 One sub-module, sevenseg_glyph_decode: combinational SEG -> {err, nibble} lookup; all sequential logic in sevenseg_decode.

Verification
REQ-031 Digits 0..3 driven SEG=1111001,0100100,0110000,0011001 for 4 cycles each, READY=1 -> VALUE=16'h4321, ERR=0, VALID pulses 1 cycle.
REQ-032 Digit 2 SEG=1111111 (blank), others legal glyph 8 -> VALUE=16'h8088, ERR=4'b0100.
REQ-033 Digit 1 held 3 cycles then DIG=0, STABLE_CYCLES=4 -> digit not accepted, no VALID.
REQ-034 Two full frames with READY=0 -> first frame held on VALUE, VALID stays 1, OVR=1; then READY=1 -> VALID=0 next cycle.
REQ-035 Frame completion coincident with VALID&&READY -> new VALUE loaded, VALID stays 1, OVR=0.
REQ-036 rst pulse after three digits accepted, then only digit 3 driven -> no VALID; VALUE=0, ERR=0.
